id_alu_issue_stage: RTL and testbench



---
 rtl/alu_issue_pkg.sv | 72 +++++++
 rtl/alu_issue_decode.sv | 118 +++++++++++
 rtl/id_alu_issue_stage.sv | 80 ++++++++
 tb/tb_id_alu_issue_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants and the issue bundle for the decode/issue stage feeding the single-cycle ALU.
package alu_issue_pkg;

    // ALU function codes
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b110000;
    localparam logic [5:0] FN_SRL  = 6'b110001;
    localparam logic [5:0] FN_SRA  = 6'b110011;
    localparam logic [5:0] FN_BLTZ = 6'b111000;
    localparam logic [5:0] FN_BGEZ = 6'b111001;
    localparam logic [5:0] FN_J    = 6'b111010;
    localparam logic [5:0] FN_JR   = 6'b111011;
    localparam logic [5:0] FN_BEQ  = 6'b111100;
    localparam logic [5:0] FN_BNE  = 6'b111101;
    localparam logic [5:0] FN_BLEZ = 6'b111110;
    localparam logic [5:0] FN_BGTZ = 6'b111111;

    // Opcodes
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // R-type funct fields
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;

    typedef struct packed {
        logic [5:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic        upper;
        logic        reg_we;
        logic [4:0]  wr_addr;
        logic        link;
        logic [31:0] link_data;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] store_data;
        logic        illegal;
    } issue_bundle_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS instruction decode into an ALU issue bundle.
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter logic [4:0] LINK_REG     = 5'd31,
    parameter logic [5:0] ILLEGAL_FUNC = 6'b000000
) (
    input  logic [31:0]   instr,
    input  logic [31:0]   pc_plus4,
    input  logic [31:0]   rs_data,
    input  logic [31:0]   rt_data,
    output issue_bundle_t bundle
);

    logic [5:0]  op, funct;
    logic [4:0]  rt, rd, shamt;
    logic [31:0] simm, zimm;
    issue_bundle_t bnd;
    logic        legal;
    logic        we;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign simm  = {{16{instr[15]}}, instr[15:0]};
    assign zimm  = {16'h0000, instr[15:0]};

    always_comb begin
        bnd   = '0;
        legal = 1'b1;
        we    = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU: begin
                        bnd.func = funct; bnd.a = rs_data; bnd.b = rt_data;
                        bnd.wr_addr = rd; we = 1'b1;
                    end
                    F_SLL, F_SRL, F_SRA: begin
                        bnd.func = (funct == F_SLL) ? FN_SLL : (funct == F_SRL) ? FN_SRL : FN_SRA;
                        bnd.a = {27'd0, shamt}; bnd.b = rt_data;
                        bnd.wr_addr = rd; we = 1'b1;
                    end
                    F_SLLV, F_SRLV, F_SRAV: begin
                        bnd.func = (funct == F_SLLV) ? FN_SLL : (funct == F_SRLV) ? FN_SRL : FN_SRA;
                        bnd.a = rs_data; bnd.b = rt_data;
                        bnd.wr_addr = rd; we = 1'b1;
                    end
                    F_JR: begin
                        bnd.func = FN_JR; bnd.a = rs_data;
                    end
                    F_JALR: begin
                        bnd.func = FN_JR; bnd.a = rs_data;
                        bnd.link = 1'b1; bnd.link_data = pc_plus4;
                        bnd.wr_addr = rd; we = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                bnd.a = rs_data; bnd.b = rt_data;
                if (rt == 5'd0)      bnd.func = FN_BLTZ;
                else if (rt == 5'd1) bnd.func = FN_BGEZ;
                else                 legal = 1'b0;
            end
            OP_J, OP_JAL: begin
                bnd.func = FN_J;
                bnd.a    = {pc_plus4[31:28], instr[25:0], 2'b00};
                if (op == OP_JAL) begin
                    bnd.link = 1'b1; bnd.link_data = pc_plus4;
                    bnd.wr_addr = LINK_REG; we = 1'b1;
                end
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                bnd.func = {4'b1111, op[1:0]};
                bnd.a = rs_data; bnd.b = rt_data;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                bnd.func = (op == OP_ADDI) ? FN_ADD : (op == OP_ADDIU) ? FN_ADDU :
                           (op == OP_SLTI) ? FN_SLT : FN_SLTU;
                bnd.a = rs_data; bnd.b = simm;
                bnd.wr_addr = rt; we = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                bnd.func = (op == OP_ANDI) ? FN_AND : (op == OP_ORI) ? FN_OR : FN_XOR;
                bnd.a = rs_data; bnd.b = zimm;
                bnd.wr_addr = rt; we = 1'b1;
            end
            OP_LUI: begin
                bnd.func = FN_ADD; bnd.b = zimm; bnd.upper = 1'b1;
                bnd.wr_addr = rt; we = 1'b1;
            end
            OP_LW: begin
                bnd.func = FN_ADD; bnd.a = rs_data; bnd.b = simm;
                bnd.mem_read = 1'b1; bnd.wr_addr = rt; we = 1'b1;
            end
            OP_SW: begin
                bnd.func = FN_ADD; bnd.a = rs_data; bnd.b = simm;
                bnd.mem_write = 1'b1; bnd.store_data = rt_data;
            end
            default: legal = 1'b0;
        endcase

        // Undecodable words still issue, with everything but the flag and func code zeroed.
        if (!legal) begin
            bnd         = '0;
            bnd.func    = ILLEGAL_FUNC;
            bnd.illegal = 1'b1;
            we          = 1'b0;
        end
        bnd.reg_we = we & (bnd.wr_addr != 5'd0);
        bundle     = bnd;
    end

endmodule

// File: rtl/id_alu_issue_stage.sv
// Decode/issue stage: one-entry output register with valid/ready handshake and branch flush.
module id_alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter logic [4:0] LINK_REG     = 5'd31,
    parameter logic [5:0] ILLEGAL_FUNC = 6'b000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc_plus4,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_func,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic        out_upper,
    output logic        out_reg_we,
    output logic [4:0]  out_wr_addr,
    output logic        out_link,
    output logic [31:0] out_link_data,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic [31:0] out_store_data,
    output logic        out_illegal
);

    issue_bundle_t dec, bnd_q;
    logic          vld_q;
    logic          take;

    alu_issue_decode #(
        .LINK_REG    (LINK_REG),
        .ILLEGAL_FUNC(ILLEGAL_FUNC)
    ) u_decode (
        .instr   (in_instr),
        .pc_plus4(in_pc_plus4),
        .rs_data (in_rs_data),
        .rt_data (in_rt_data),
        .bundle  (dec)
    );

    assign in_ready = ~flush & (~vld_q | out_ready);
    assign take     = in_valid & in_ready;

    // Flush only drops valid; the stale bundle is left in place since nothing consumes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            bnd_q <= '0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (take) begin
            vld_q <= 1'b1;
            bnd_q <= dec;
        end else if (out_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign out_valid      = vld_q;
    assign out_func       = bnd_q.func;
    assign out_a          = bnd_q.a;
    assign out_b          = bnd_q.b;
    assign out_upper      = bnd_q.upper;
    assign out_reg_we     = bnd_q.reg_we;
    assign out_wr_addr    = bnd_q.wr_addr;
    assign out_link       = bnd_q.link;
    assign out_link_data  = bnd_q.link_data;
    assign out_mem_read   = bnd_q.mem_read;
    assign out_mem_write  = bnd_q.mem_write;
    assign out_store_data = bnd_q.store_data;
    assign out_illegal    = bnd_q.illegal;

endmodule

// File: tb/tb_id_alu_issue_stage.sv
// Self-checking bench: directed cases plus randomized traffic against a table-driven reference model.
module tb_id_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc_plus4, in_rs_data, in_rt_data;
    logic [5:0]  out_func;
    logic [31:0] out_a, out_b, out_link_data, out_store_data;
    logic        out_upper, out_reg_we, out_link, out_mem_read, out_mem_write, out_illegal;
    logic [4:0]  out_wr_addr;

    always #5 clk = ~clk;

    id_alu_issue_stage #(.LINK_REG(5'd31), .ILLEGAL_FUNC(6'b000000)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc_plus4(in_pc_plus4), .in_rs_data(in_rs_data),
        .in_rt_data(in_rt_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_func(out_func), .out_a(out_a), .out_b(out_b), .out_upper(out_upper),
        .out_reg_we(out_reg_we), .out_wr_addr(out_wr_addr), .out_link(out_link),
        .out_link_data(out_link_data), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_store_data(out_store_data), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [5:0]  func;
        logic [31:0] a, b;
        logic        upper, reg_we;
        logic [4:0]  wr;
        logic        link;
        logic [31:0] link_data;
        logic        mem_read, mem_write;
        logic [31:0] store_data;
        logic        illegal;
    } exp_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Decode tables indexed by opcode / funct: kind selects the operand recipe.
    logic [5:0] ifn[64], rfn[64];
    int         ikind[64], rkind[64];

    localparam int K_ILL = 0, K_SEXT = 1, K_ZEXT = 2, K_LUI = 3, K_LW = 4, K_SW = 5,
                   K_BR = 6, K_J = 7, K_JAL = 8, K_REGIMM = 9, K_R = 10;
    localparam int R_ARITH = 1, R_SHAMT = 2, R_JR = 3, R_JALR = 4;

    task automatic init_tables();
        for (int k = 0; k < 64; k++) begin
            ikind[k] = K_ILL; rkind[k] = 0; ifn[k] = 6'd0; rfn[k] = 6'd0;
        end
        for (int k = 32; k <= 39; k++) begin rkind[k] = R_ARITH; rfn[k] = 6'(k); end
        rkind[42] = R_ARITH; rfn[42] = 6'd42;
        rkind[43] = R_ARITH; rfn[43] = 6'd43;
        rkind[0] = R_SHAMT; rfn[0] = 6'h30;
        rkind[2] = R_SHAMT; rfn[2] = 6'h31;
        rkind[3] = R_SHAMT; rfn[3] = 6'h33;
        rkind[4] = R_ARITH; rfn[4] = 6'h30;
        rkind[6] = R_ARITH; rfn[6] = 6'h31;
        rkind[7] = R_ARITH; rfn[7] = 6'h33;
        rkind[8] = R_JR;    rfn[8] = 6'h3B;
        rkind[9] = R_JALR;  rfn[9] = 6'h3B;
        ikind[0] = K_R; ikind[1] = K_REGIMM;
        ikind[2] = K_J; ifn[2] = 6'h3A;
        ikind[3] = K_JAL; ifn[3] = 6'h3A;
        ikind[4] = K_BR; ifn[4] = 6'h3C;
        ikind[5] = K_BR; ifn[5] = 6'h3D;
        ikind[6] = K_BR; ifn[6] = 6'h3E;
        ikind[7] = K_BR; ifn[7] = 6'h3F;
        ikind[8]  = K_SEXT; ifn[8]  = 6'h20;
        ikind[9]  = K_SEXT; ifn[9]  = 6'h21;
        ikind[10] = K_SEXT; ifn[10] = 6'h2A;
        ikind[11] = K_SEXT; ifn[11] = 6'h2B;
        ikind[12] = K_ZEXT; ifn[12] = 6'h24;
        ikind[13] = K_ZEXT; ifn[13] = 6'h25;
        ikind[14] = K_ZEXT; ifn[14] = 6'h26;
        ikind[15] = K_LUI;  ifn[15] = 6'h20;
        ikind[35] = K_LW;   ifn[35] = 6'h20;
        ikind[43] = K_SW;   ifn[43] = 6'h20;
    endtask

    function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] pc,
                                     input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        int   op  = int'(i[31:26]);
        int   fu  = int'(i[5:0]);
        int   rtn = int'(i[20:16]);
        int   rdn = int'(i[15:11]);
        logic [31:0] sx = {{16{i[15]}}, i[15:0]};
        logic [31:0] zx = {16'h0000, i[15:0]};
        bit   ok = 1;
        e = '{func: 6'd0, a: 32'd0, b: 32'd0, upper: 1'b0, reg_we: 1'b0, wr: 5'd0, link: 1'b0,
              link_data: 32'd0, mem_read: 1'b0, mem_write: 1'b0, store_data: 32'd0, illegal: 1'b0};
        case (ikind[op])
            K_SEXT, K_ZEXT: begin
                e.func = ifn[op]; e.a = rs; e.b = (ikind[op] == K_SEXT) ? sx : zx;
                e.wr = 5'(rtn); e.reg_we = 1;
            end
            K_LUI:  begin e.func = ifn[op]; e.b = zx; e.upper = 1; e.wr = 5'(rtn); e.reg_we = 1; end
            K_LW:   begin e.func = ifn[op]; e.a = rs; e.b = sx; e.mem_read = 1; e.wr = 5'(rtn); e.reg_we = 1; end
            K_SW:   begin e.func = ifn[op]; e.a = rs; e.b = sx; e.mem_write = 1; e.store_data = rt; end
            K_BR:   begin e.func = ifn[op]; e.a = rs; e.b = rt; end
            K_J, K_JAL: begin
                e.func = ifn[op];
                e.a = (pc & 32'hF000_0000) + ({6'd0, i[25:0]} * 4);
                if (ikind[op] == K_JAL) begin
                    e.link = 1; e.link_data = pc; e.wr = 5'd31; e.reg_we = 1;
                end
            end
            K_REGIMM: begin
                if (rtn < 2) begin e.func = 6'(6'h38 + rtn); e.a = rs; e.b = rt; end
                else ok = 0;
            end
            K_R: begin
                case (rkind[fu])
                    R_ARITH: begin e.func = rfn[fu]; e.a = rs; e.b = rt; e.wr = 5'(rdn); e.reg_we = 1; end
                    R_SHAMT: begin e.func = rfn[fu]; e.a = 32'(i[10:6]); e.b = rt; e.wr = 5'(rdn); e.reg_we = 1; end
                    R_JR:    begin e.func = rfn[fu]; e.a = rs; end
                    R_JALR:  begin
                        e.func = rfn[fu]; e.a = rs; e.link = 1; e.link_data = pc;
                        e.wr = 5'(rdn); e.reg_we = 1;
                    end
                    default: ok = 0;
                endcase
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '{func: 6'd0, a: 32'd0, b: 32'd0, upper: 1'b0, reg_we: 1'b0, wr: 5'd0, link: 1'b0,
                  link_data: 32'd0, mem_read: 1'b0, mem_write: 1'b0, store_data: 32'd0, illegal: 1'b1};
        end
        if (e.wr == 5'd0) e.reg_we = 0;
        return e;
    endfunction

    exp_t m;
    logic m_valid;

    task automatic chk_out();
        chk("out_valid",      32'(out_valid),      32'(m_valid));
        chk("out_func",       32'(out_func),       32'(m.func));
        chk("out_a",          out_a,               m.a);
        chk("out_b",          out_b,               m.b);
        chk("out_upper",      32'(out_upper),      32'(m.upper));
        chk("out_reg_we",     32'(out_reg_we),     32'(m.reg_we));
        chk("out_wr_addr",    32'(out_wr_addr),    32'(m.wr));
        chk("out_link",       32'(out_link),       32'(m.link));
        chk("out_link_data",  out_link_data,       m.link_data);
        chk("out_mem_read",   32'(out_mem_read),   32'(m.mem_read));
        chk("out_mem_write",  32'(out_mem_write),  32'(m.mem_write));
        chk("out_store_data", out_store_data,      m.store_data);
        chk("out_illegal",    32'(out_illegal),    32'(m.illegal));
    endtask

    // One clock: drive, check in_ready, clock, advance model, check registered outputs.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic rdy, input logic fl, input logic rst);
        logic rdy_exp;
        exp_t nb;
        in_valid = v; in_instr = ins; in_pc_plus4 = pc; in_rs_data = rs; in_rt_data = rt;
        out_ready = rdy; flush = fl; reset = rst;
        #1;
        rdy_exp = ~fl & (~m_valid | rdy);
        chk("in_ready", 32'(in_ready), 32'(rdy_exp));
        nb = ref_dec(ins, pc, rs, rt);
        @(posedge clk);
        if (rst) begin
            m_valid = 0;
            m = '{func: 6'd0, a: 32'd0, b: 32'd0, upper: 1'b0, reg_we: 1'b0, wr: 5'd0, link: 1'b0,
                  link_data: 32'd0, mem_read: 1'b0, mem_write: 1'b0, store_data: 32'd0, illegal: 1'b0};
        end else if (fl) m_valid = 0;
        else if (v && rdy_exp) begin m_valid = 1; m = nb; end
        else if (rdy) m_valid = 0;
        #1;
        chk_out();
    endtask

    logic [5:0] ops[20] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                           6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h00};
    logic [5:0] fns[18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h20,
                           6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    function automatic logic [31:0] rand_instr();
        logic [31:0] i = $urandom;
        int r = $urandom_range(0, 9);
        if (r < 8) begin
            i[31:26] = ops[$urandom_range(0, 19)];
            if (i[31:26] == 6'h00 && r < 7) i[5:0] = fns[$urandom_range(0, 17)];
            if (i[31:26] == 6'h01) i[20:16] = 5'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 7) == 0) i[15:11] = 5'd0;
        if ($urandom_range(0, 7) == 0) i[20:16] = 5'd0;
        return i;
    endfunction

    localparam logic [31:0] ADDU = 32'h0022_1821;
    localparam logic [31:0] SRA  = 32'h0002_20C3;
    localparam logic [31:0] LUI  = 32'h3C05_1234;
    localparam logic [31:0] LW   = 32'h8C26_FFFC;
    localparam logic [31:0] SW   = 32'hAC26_FFFC;
    localparam logic [31:0] JAL  = 32'h0C10_0004;
    localparam logic [31:0] ILL  = 32'hFC00_0000;
    localparam logic [31:0] PC   = 32'h1000_0004;

    initial begin
        init_tables();
        m_valid = 0;
        m = '{func: 6'd0, a: 32'd0, b: 32'd0, upper: 1'b0, reg_we: 1'b0, wr: 5'd0, link: 1'b0,
              link_data: 32'd0, mem_read: 1'b0, mem_write: 1'b0, store_data: 32'd0, illegal: 1'b0};
        reset = 1; in_valid = 0; in_instr = 0; in_pc_plus4 = 0; in_rs_data = 0; in_rt_data = 0;
        out_ready = 0; flush = 0;

        step(1, ADDU, PC, 5, 7, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        chk("rst_valid", 32'(out_valid), 32'd0);

        step(1, ADDU, PC, 5, 7, 1, 0, 0);
        chk("addu_func", 32'(out_func), 32'h21);
        chk("addu_a", out_a, 32'd5);
        chk("addu_b", out_b, 32'd7);
        chk("addu_wr", 32'(out_wr_addr), 32'd3);
        chk("addu_we", 32'(out_reg_we), 32'd1);

        step(1, SRA, PC, 9, 32'h8000_0000, 1, 0, 0);
        chk("sra_func", 32'(out_func), 32'h33);
        chk("sra_a", out_a, 32'd3);
        chk("sra_b", out_b, 32'h8000_0000);

        step(1, LUI, PC, 9, 1, 1, 0, 0);
        chk("lui_upper", 32'(out_upper), 32'd1);
        chk("lui_a", out_a, 32'd0);
        chk("lui_b", out_b, 32'h1234);

        step(1, LW, PC, 32'h100, 32'h55, 1, 0, 0);
        chk("lw_b", out_b, 32'hFFFF_FFFC);
        chk("lw_mem_read", 32'(out_mem_read), 32'd1);

        step(1, SW, PC, 32'h100, 32'hDEAD_BEEF, 1, 0, 0);
        chk("sw_mem_write", 32'(out_mem_write), 32'd1);
        chk("sw_store_data", out_store_data, 32'hDEAD_BEEF);
        chk("sw_reg_we", 32'(out_reg_we), 32'd0);

        step(1, JAL, PC, 1, 2, 1, 0, 0);
        chk("jal_func", 32'(out_func), 32'h3A);
        chk("jal_a", out_a, 32'h1040_0010);
        chk("jal_link", 32'(out_link), 32'd1);
        chk("jal_wr", 32'(out_wr_addr), 32'd31);
        chk("jal_link_data", out_link_data, PC);

        // Stall with addu waiting behind the held jal.
        for (int k = 0; k < 3; k++) begin
            step(1, ADDU, PC, 11, 12, 0, 0, 0);
            chk("stall_a", out_a, 32'h1040_0010);
        end
        step(1, ADDU, PC, 11, 12, 1, 0, 0);
        chk("post_stall_a", out_a, 32'd11);
        step(0, 0, PC, 0, 0, 1, 0, 0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        step(1, SRA, PC, 0, 4, 1, 0, 0);
        step(1, LUI, PC, 0, 0, 1, 1, 0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_upper", 32'(out_upper), 32'd0);

        step(1, ILL, PC, 3, 4, 1, 0, 0);
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_func", 32'(out_func), 32'd0);
        chk("ill_valid", 32'(out_valid), 32'd1);

        step(1, ADDU, PC, 5, 7, 1, 0, 0);
        step(1, LUI, PC, 5, 7, 0, 0, 0);
        step(1, LUI, PC, 5, 7, 0, 0, 1);
        chk("rst_stall_a", out_a, 32'd0);
        chk("rst_stall_valid", 32'(out_valid), 32'd0);

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
